mem_reader: RTL

MEM_READER -- requirements
Module: mem_reader

---
 rtl/mem_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_reader.sv
// mem_reader: reads a burst of bytes from a synchronous-read memory and
// streams them out through a 2-entry ready/valid FIFO in address order.
//
// Build option: MEM_READER_WRAP_EN
//   defined   - addresses wrap from the top of memory to 0 and every requested
//               byte is delivered; err never sets.
//   undefined - a burst running past the top of memory is truncated at the
//               last address and err is raised when the burst completes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; start_addr/length latched on start
// S_READ  | issuing memory reads while the FIFO has room
// S_DRAIN | every read issued, waiting for the remaining bytes to leave
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module mem_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] d_out,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_issue_left;
    logic [ADDR_W:0]   r_xfer_left;
    logic              r_ovr;
    logic              r_err;
    logic              r_pending;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_xfer;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_last_xfer;
    logic [2:0]        w_occ;
    logic [ADDR_W:0]   w_eff_len;
    logic              w_ovr;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign d_valid      = (r_count != 2'd0);
    assign d_out        = r_fifo[r_rd_ptr];
    assign w_xfer       = d_valid && d_ready;
    // Occupancy counts bytes already buffered plus the one read in flight;
    // a byte leaving this cycle frees a slot for a read issued this cycle.
    assign w_occ        = {1'b0, r_count} + {2'b00, r_pending};
    assign w_issue      = (r_state == S_READ) && (w_occ < (3'd2 + {2'b00, w_xfer}));
    assign w_last_issue = w_issue && (r_issue_left == ONE);
    assign w_last_xfer  = (r_state == S_DRAIN) && w_xfer && (r_xfer_left == ONE);

    assign mem_rd_en = w_issue;
    assign mem_addr  = r_addr;
    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

`ifdef MEM_READER_WRAP_EN
    // Wrapping build: the whole requested length is always read.
    always_comb begin
        w_eff_len = length;
        w_ovr     = 1'b0;
    end
`else
    logic [ADDR_W:0] w_room;
    assign w_room = {1'b1, {ADDR_W{1'b0}}} - {1'b0, start_addr};

    // Truncating build: clip the burst at the top of memory and remember it.
    always_comb begin
        w_ovr     = (length > w_room);
        w_eff_len = w_ovr ? w_room : length;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (length == '0) ? S_DONE : S_READ;
            S_READ:  if (w_last_issue) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_xfer) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst bookkeeping: address, remaining counts, in-flight read, err flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_xfer_left  <= '0;
            r_ovr        <= 1'b0;
            r_err        <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_pending <= w_issue;
            if (w_accept) begin
                r_addr       <= start_addr;
                r_issue_left <= w_eff_len;
                r_xfer_left  <= w_eff_len;
                r_ovr        <= w_ovr;
                r_err        <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + 1'b1;
                    r_issue_left <= r_issue_left - ONE;
                end
                if (w_xfer) r_xfer_left <= r_xfer_left - ONE;
                if (w_last_xfer) r_err <= r_ovr;
            end
        end
    end

    // Two-entry output FIFO; read data is captured the cycle it is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (r_pending) begin
                r_fifo[r_wr_ptr] <= mem_rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_xfer) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_pending} - {1'b0, w_xfer};
        end
    end

endmodule
